// File: rtl/rv32i_types.sv
// Shared RV32I core types used by the rename stage and the free list.
package rv32i_types;

    localparam int ARCH_REGS = 32;
    localparam int PR_W      = 6;

    // Physical register index (64 physical registers in the default core)
    typedef logic [PR_W-1:0] pr_idx_t;

    // Free-list pointer for the default configuration: 32 entries plus a wrap bit
    localparam int FL_DEPTH = 32;
    typedef logic [$clog2(FL_DEPTH):0] fl_ptr_t;

endpackage

// File: rtl/free_list_if.sv
// Dispatcher / ROB-commit side interface of the physical register free list.
interface free_list_if
    import rv32i_types::*;
#(
    parameter int SS = 2
) ();

    logic             pop;
    pr_idx_t [SS-1:0] free_rat_rds;
    logic             empty;
    logic [SS-1:0]    push_en;
    pr_idx_t [SS-1:0] push_pr;
    logic             flush;
    logic             overflow;

    modport master (
        output pop, push_en, push_pr, flush,
        input  free_rat_rds, empty, overflow
    );

    modport slave (
        input  pop, push_en, push_pr, flush,
        output free_rat_rds, empty, overflow
    );

endinterface

// File: rtl/free_list.sv
// Circular free list of physical registers. Dispatch pops SS PRs per cycle
// (data registered, valid the next cycle), commit pushes freed PRs back, and
// a flush rewinds head so every speculatively handed-out PR is free again.
module free_list
    import rv32i_types::*;
#(
    parameter int SS         = 2,
    parameter int PR_ENTRIES = 64,
    parameter int DEPTH      = PR_ENTRIES - ARCH_REGS
) (
    input  logic       clk,
    input  logic       rst,
    free_list_if.slave fl
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    typedef logic [PW-1:0] ptr_t;

    pr_idx_t          fl_buf_r [DEPTH];
    ptr_t             head_r;
    ptr_t             tail_r;
    pr_idx_t [SS-1:0] rds_r;
    logic             empty_r;
    logic             overflow_r;

    logic             pop_ok_s;
    ptr_t             head_pop_s;
    ptr_t             tail_v_s;
    ptr_t             cnt_v_s;
    ptr_t             head_n_s;
    ptr_t             tail_n_s;
    ptr_t             cnt_n_s;
    logic             empty_n_s;
    logic             ovf_set_s;
    logic [SS-1:0]    wr_en_s;
    logic [IW-1:0]    wr_idx_s [SS];

    // Next-state pointers: pop first, then lane-ordered pushes against the post-pop count, then flush rewind
    always_comb begin
        pop_ok_s   = fl.pop & ~empty_r & ~fl.flush;
        head_pop_s = pop_ok_s ? (head_r + PW'(SS)) : head_r;
        tail_v_s   = tail_r;
        cnt_v_s    = (tail_r - head_r) - (pop_ok_s ? PW'(SS) : {PW{1'b0}});
        ovf_set_s  = 1'b0;
        for (int i = 0; i < SS; i++) begin
            wr_en_s[i]  = 1'b0;
            wr_idx_s[i] = tail_v_s[IW-1:0];
            if (fl.push_en[i] && (fl.push_pr[i] != 6'd0)) begin
                if (cnt_v_s == PW'(DEPTH)) begin
                    ovf_set_s = 1'b1;
                end else begin
                    wr_en_s[i] = 1'b1;
                    tail_v_s   = tail_v_s + PW'(1);
                    cnt_v_s    = cnt_v_s + PW'(1);
                end
            end else begin
                wr_en_s[i] = 1'b0;
            end
        end
        tail_n_s = tail_v_s;
        if (fl.flush) begin
            // Same index as tail, opposite lap: the whole ring is free again
            head_n_s = {~tail_v_s[PW-1], tail_v_s[IW-1:0]};
        end else begin
            head_n_s = head_pop_s;
        end
        cnt_n_s   = tail_n_s - head_n_s;
        empty_n_s = (cnt_n_s < PW'(SS));
    end

    // Pointer, buffer, pop data and status registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_buf_r[i] <= pr_idx_t'(ARCH_REGS + i);
            end
            head_r     <= {PW{1'b0}};
            tail_r     <= {1'b1, {IW{1'b0}}};
            rds_r      <= {(SS*PR_W){1'b0}};
            empty_r    <= (DEPTH < SS);
            overflow_r <= 1'b0;
        end else begin
            for (int i = 0; i < SS; i++) begin
                if (wr_en_s[i]) begin
                    fl_buf_r[wr_idx_s[i]] <= fl.push_pr[i];
                end
            end
            if (pop_ok_s) begin
                for (int i = 0; i < SS; i++) begin
                    rds_r[i] <= fl_buf_r[head_r[IW-1:0] + IW'(i)];
                end
            end
            head_r     <= head_n_s;
            tail_r     <= tail_n_s;
            empty_r    <= empty_n_s;
            overflow_r <= overflow_r | ovf_set_s;
        end
    end

    assign fl.free_rat_rds = rds_r;
    assign fl.empty        = empty_r;
    assign fl.overflow     = overflow_r;

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list (SS=2, 64 PRs, 32-entry list).
module tb_free_list;
    import rv32i_types::*;

    localparam int SS = 2;

    logic clk;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;

    free_list_if #(.SS(SS)) fl_if ();

    free_list #(.SS(SS), .PR_ENTRIES(64), .DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .fl  (fl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        fl_if.pop     = 1'b0;
        fl_if.flush   = 1'b0;
        fl_if.push_en = 2'b00;
        fl_if.push_pr = {6'd0, 6'd0};
    endtask

    task automatic check_out(input string tag, input int e0, input int e1, input logic emp);
        check({tag, ".rd0"}, 32'(fl_if.free_rat_rds[0]), 32'(e0));
        check({tag, ".rd1"}, 32'(fl_if.free_rat_rds[1]), 32'(e1));
        check({tag, ".empty"}, 32'(fl_if.empty), 32'(emp));
    endtask

    task automatic pop_chk(input string tag, input int e0, input int e1, input logic emp);
        fl_if.pop = 1'b1;
        step();
        fl_if.pop = 1'b0;
        check_out(tag, e0, e1, emp);
    endtask

    task automatic push_do(input logic [1:0] en, input int p0, input int p1);
        fl_if.push_en = en;
        fl_if.push_pr = {6'(p1), 6'(p0)};
        step();
        fl_if.push_en = 2'b00;
        fl_if.push_pr = {6'd0, 6'd0};
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        step();
        step();
        check_out("rst", 0, 0, 1'b0);
        check("rst.ovf", 32'(fl_if.overflow), 32'd0);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        #2;
        do_reset();

        // Drain the full list: 16 pairs in order, empty after the 16th
        for (int k = 0; k < 16; k++) begin
            pop_chk("drain", 32 + 2*k, 33 + 2*k, (k == 15));
        end
        pop_chk("pop_on_empty", 62, 63, 1'b1);

        // Push into empty list, then pop it back
        push_do(2'b11, 40, 41);
        check("push2.empty", 32'(fl_if.empty), 32'd0);
        pop_chk("pop_pushed", 40, 41, 1'b1);

        // Pop and push together at count == 2
        push_do(2'b11, 50, 51);
        fl_if.push_en = 2'b11;
        fl_if.push_pr = {6'd53, 6'd52};
        pop_chk("pop_push", 50, 51, 1'b0);
        fl_if.push_en = 2'b00;
        pop_chk("pop_after", 52, 53, 1'b1);

        // PR 0 pushes are dropped without moving tail
        push_do(2'b11, 0, 0);
        check("zero.empty", 32'(fl_if.empty), 32'd1);
        push_do(2'b11, 0, 44);
        check("zero1.empty", 32'(fl_if.empty), 32'd1);
        push_do(2'b11, 45, 0);
        check("zero2.empty", 32'(fl_if.empty), 32'd0);
        pop_chk("zero_pop", 44, 45, 1'b1);
        check("zero.ovf", 32'(fl_if.overflow), 32'd0);

        // Full list: push with same-cycle pop is accepted, push alone overflows
        do_reset();
        fl_if.push_en = 2'b11;
        fl_if.push_pr = {6'd46, 6'd45};
        pop_chk("full_pop_push", 32, 33, 1'b0);
        fl_if.push_en = 2'b00;
        check("full_pop_push.ovf", 32'(fl_if.overflow), 32'd0);
        push_do(2'b01, 47, 0);
        check("ovf.set", 32'(fl_if.overflow), 32'd1);
        for (int k = 0; k < 15; k++) begin
            pop_chk("ovf_drain", 34 + 2*k, 35 + 2*k, 1'b0);
        end
        pop_chk("ovf_last", 45, 46, 1'b1);
        check("ovf.sticky", 32'(fl_if.overflow), 32'd1);

        // Asynchronous reset mid-stream
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pop_chk("pre_rst", 32 + 2*k, 33 + 2*k, 1'b0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_out("async_rst", 0, 0, 1'b0);
        check("async_rst.ovf", 32'(fl_if.overflow), 32'd0);
        step();
        rst = 1'b1;
        pop_chk("post_rst", 32, 33, 1'b0);

        // Flush: pop 4, return them, pop 4 more, flush, then drain the rewound ring
        do_reset();
        for (int k = 0; k < 4; k++) begin
            pop_chk("fl_pre", 32 + 2*k, 33 + 2*k, 1'b0);
        end
        for (int k = 0; k < 4; k++) begin
            push_do(2'b11, 32 + 2*k, 33 + 2*k);
        end
        for (int k = 0; k < 4; k++) begin
            pop_chk("fl_spec", 40 + 2*k, 41 + 2*k, 1'b0);
        end
        fl_if.flush = 1'b1;
        pop_chk("flush_hold", 46, 47, 1'b0);
        fl_if.flush = 1'b0;
        for (int k = 0; k < 16; k++) begin
            pop_chk("fl_drain", 32 + ((8 + 2*k) % 32), 33 + ((8 + 2*k) % 32), (k == 15));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
